// File: rtl/fc_layer_mac.sv
// Fully-connected layer: collects an IN_DIM activation vector, then computes and streams
// OUT_DIM biased dot products using 1-cycle-latency weight/bias ROMs. ROM contents come from W_INIT/B_INIT.
module fc_layer_mac #(
   parameter int IN_DIM     = 32,
   parameter int OUT_DIM    = 10,
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 24,
   parameter int BIAS_SHIFT = 0,
   parameter int RELU       = 1,
   parameter logic [IN_DIM*OUT_DIM*DATA_W-1:0] W_INIT = '0,
   parameter logic [OUT_DIM*DATA_W-1:0]        B_INIT = '0,
   localparam int IDX_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              busy
);

   localparam int W_DEPTH = IN_DIM * OUT_DIM;
   localparam int W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
   localparam int X_AW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
   localparam int CNT_W   = $clog2(IN_DIM + 2);
   localparam int PROD_W  = 2 * DATA_W;

   typedef enum logic [1:0] {COLLECT, PREP, MAC, EMIT} state_t;

   state_t                    state_reg, state_next;
   logic                      armed_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic [IDX_W-1:0]          o_reg;
   logic [W_AW-1:0]           base_reg;
   logic [W_AW-1:0]           w_addr;
   logic signed [DATA_W-1:0]  x_mem [IN_DIM];
   logic signed [DATA_W-1:0]  w_rom [W_DEPTH];
   logic signed [DATA_W-1:0]  b_rom [OUT_DIM];
   logic signed [DATA_W-1:0]  w_q_reg, b_q_reg, x_sel;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_reg, acc_next, bias_ext, result;
   logic                      accept, last_neuron, mac_first, mac_last;

   genvar gi;
   generate
      for (gi = 0; gi < W_DEPTH; gi++) begin : g_wrom
         assign w_rom[gi] = W_INIT[gi*DATA_W +: DATA_W];
      end
      for (gi = 0; gi < OUT_DIM; gi++) begin : g_brom
         assign b_rom[gi] = B_INIT[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign accept      = in_valid && in_ready;
   assign last_neuron = (o_reg == IDX_W'(OUT_DIM - 1));
   assign mac_first   = (cnt_reg == '0);
   assign mac_last    = (cnt_reg == CNT_W'(IN_DIM));

   // Address for MAC step k is issued one cycle ahead of its use; the final step re-reads the row base.
   assign w_addr = (state_reg == MAC && cnt_reg < CNT_W'(IN_DIM)) ? base_reg + W_AW'(cnt_reg) : base_reg;

   always_ff @(posedge clk) begin
      w_q_reg <= w_rom[w_addr];
      b_q_reg <= b_rom[o_reg];
   end

   always_ff @(posedge clk) begin
      if (accept) x_mem[X_AW'(cnt_reg)] <= in_data;
   end

   assign x_sel    = x_mem[X_AW'(cnt_reg - CNT_W'(1))];
   assign prod     = w_q_reg * x_sel;
   assign acc_next = acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W){b_q_reg[DATA_W-1]}}, b_q_reg} <<< BIAS_SHIFT;
   assign result   = (RELU != 0 && acc_next[ACC_W-1]) ? '0 : acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= COLLECT;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         COLLECT: if (accept && cnt_reg == CNT_W'(IN_DIM - 1)) state_next = PREP;
         PREP:    state_next = MAC;
         MAC:     if (mac_last) state_next = EMIT;
         EMIT:    if (out_ready) state_next = last_neuron ? COLLECT : PREP;
         default: state_next = COLLECT;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == COLLECT) && armed_reg;
      out_valid = (state_reg == EMIT);
      busy      = (state_reg != COLLECT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_reg <= 1'b0;
         cnt_reg   <= '0;
         o_reg     <= '0;
         base_reg  <= '0;
         acc_reg   <= '0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         armed_reg <= 1'b1;
         case (state_reg)
            COLLECT: if (accept) cnt_reg <= cnt_reg + CNT_W'(1);
            PREP:    cnt_reg <= '0;
            MAC: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               acc_reg <= mac_first ? bias_ext : acc_next;
               if (mac_last) begin
                  out_data <= result;
                  out_idx  <= o_reg;
                  out_last <= last_neuron;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  cnt_reg <= '0;
                  if (last_neuron) begin
                     o_reg    <= '0;
                     base_reg <= '0;
                  end else begin
                     o_reg    <= o_reg + IDX_W'(1);
                     base_reg <= base_reg + W_AW'(IN_DIM);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_mac.sv
// Bench for fc_layer_mac: three lockstep instances (RELU off, RELU on, shifted bias) checked
// every cycle against a plain-arithmetic dot-product model with random stimulus and backpressure.
module tb_fc_layer_mac;

   localparam int IN_DIM = 4;
   localparam int OUT_DIM = 3;
   localparam int DATA_W = 8;
   localparam int ACC_W = 24;
   // rows: [-128 x4], [127 x4], [1 x4]; element [o*IN_DIM+i] lives at bits [8*(o*4+i) +: 8]
   localparam logic [95:0] W_A = {32'h01010101, 32'h7F7F7F7F, 32'h80808080};
   localparam logic [23:0] B_A = {8'h00, 8'hFD, 8'h05};
   localparam logic [23:0] B_C = {8'h7F, 8'hFF, 8'h01};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready_a, in_ready_b, in_ready_c;
   logic              out_valid_a, out_valid_b, out_valid_c;
   logic [ACC_W-1:0]  out_data_a, out_data_b, out_data_c;
   logic [1:0]        out_idx_a, out_idx_b, out_idx_c;
   logic              out_last_a, out_last_b, out_last_c;
   logic              busy_a, busy_b, busy_c;

   always #5 clk = ~clk;

   fc_layer_mac #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W), .ACC_W(ACC_W),
                  .BIAS_SHIFT(0), .RELU(0), .W_INIT(W_A), .B_INIT(B_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_idx(out_idx_a),
      .out_last(out_last_a), .busy(busy_a));

   fc_layer_mac #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W), .ACC_W(ACC_W),
                  .BIAS_SHIFT(0), .RELU(1), .W_INIT(W_A), .B_INIT(B_A)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_idx(out_idx_b),
      .out_last(out_last_b), .busy(busy_b));

   fc_layer_mac #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W), .ACC_W(ACC_W),
                  .BIAS_SHIFT(4), .RELU(0), .W_INIT('0), .B_INIT(B_C)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
      .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .out_idx(out_idx_c),
      .out_last(out_last_c), .busy(busy_c));

   int w_a [3][4] = '{'{-128, -128, -128, -128}, '{127, 127, 127, 127}, '{1, 1, 1, 1}};
   int b_a [3] = '{5, -3, 0};
   int b_c [3] = '{1, -1, 127};

   typedef struct {int da; int db; int dc; int idx; bit last;} exp_t;
   exp_t expq[$];

   int tests = 0, fails = 0;
   int cyc = 0, ev_cyc = 0, elem = 0, rel_cnt = 0;
   bit hold = 0;
   bit prev_valid = 0, prev_ready = 0;
   logic [ACC_W-1:0] prev_data = '0;
   logic [1:0] prev_idx = '0;

   // set 0: RELU off, set 1: RELU on, set 2: zero weights with bias scaled by 16
   function automatic int model(input int set, input int o, input int xv[4]);
      int s;
      if (set == 2) s = b_c[o] * 16;
      else begin
         s = b_a[o];
         for (int i = 0; i < IN_DIM; i++) s += w_a[o][i] * xv[i];
      end
      if (set == 1 && s < 0) s = 0;
      return s;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic send_frame(input int xv[4], input bit gaps);
      exp_t e;
      bit ok;
      for (int o = 0; o < OUT_DIM; o++) begin
         e.da = model(0, o, xv);
         e.db = model(1, o, xv);
         e.dc = model(2, o, xv);
         e.idx = o;
         e.last = (o == OUT_DIM - 1);
         expq.push_back(e);
      end
      for (int i = 0; i < IN_DIM; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data = 8'(xv[i]);
         ok = 0;
         for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready_a) begin ok = 1; break; end
         end
         if (!ok) fail_now("in_ready_wait");
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (expq.size() == 0 && !busy_a) begin ok = 1; break; end
      end
      if (!ok) fail_now("drain");
      @(posedge clk); #1;
   endtask

   function automatic void rand_vec(output int xv[4]);
      for (int i = 0; i < IN_DIM; i++) begin
         case ($urandom_range(0, 5))
            0:       xv[i] = -128;
            1:       xv[i] = 127;
            default: xv[i] = int'($urandom_range(0, 255)) - 128;
         endcase
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid_a, 0);
         chk("rst_in_ready", in_ready_a, 0);
         chk("rst_busy", busy_a, 0);
         chk("rst_out_data", $signed(out_data_a), 0);
         chk("rst_out_idx", out_idx_a, 0);
         chk("rst_out_last", out_last_a, 0);
         expq.delete();
         elem = 0;
         rel_cnt = 0;
         prev_valid = 0;
         prev_ready = 0;
      end else begin
         if (rel_cnt == 1) chk("in_ready_after_release", in_ready_a, 1);
         if (rel_cnt >= 1) chk("in_ready_vs_busy", in_ready_a, !busy_a);
         if (rel_cnt < 2) rel_cnt++;
         chk("lockstep_valid", {out_valid_b, out_valid_c}, {2{out_valid_a}});
         if (in_valid && in_ready_a) begin
            elem++;
            if (elem == IN_DIM) begin elem = 0; ev_cyc = cyc; end
         end
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", out_valid_a, 1);
            chk("hold_data", out_data_a, prev_data);
            chk("hold_idx", out_idx_a, prev_idx);
         end
         if (prev_valid && prev_ready) chk("valid_drop", out_valid_a, 0);
         if (out_valid_a) begin
            if (!prev_valid) chk("latency", cyc - ev_cyc, IN_DIM + 3);
            if (expq.size() == 0) begin
               fails++;
               tests++;
               $display("FAIL unexpected_output: idx %0d data %0d with nothing expected", out_idx_a, $signed(out_data_a));
            end else begin
               chk("data_relu0", $signed(out_data_a), expq[0].da);
               chk("data_relu1", $signed(out_data_b), expq[0].db);
               chk("data_shift", $signed(out_data_c), expq[0].dc);
               chk("out_idx", out_idx_a, expq[0].idx);
               chk("out_last", out_last_a, expq[0].last);
               if (out_ready) begin
                  $display("[TB] out idx=%0d last=%0d a=%0d b=%0d c=%0d", out_idx_a, out_last_a,
                           $signed(out_data_a), $signed(out_data_b), $signed(out_data_c));
                  if (!out_last_a) ev_cyc = cyc;
                  void'(expq.pop_front());
               end
            end
         end
         prev_valid = out_valid_a;
         prev_ready = out_ready;
         prev_data = out_data_a;
         prev_idx = out_idx_a;
      end
   end

   initial begin
      int xv[4];
      bit ok;

      xv = '{-128, -128, -128, -128};
      chk("pin_model_a0", model(0, 0, xv), 65541);
      chk("pin_model_a1", model(0, 1, xv), -65027);
      chk("pin_model_b1", model(1, 1, xv), 0);
      chk("pin_model_c0", model(2, 0, xv), 16);
      xv = '{1, 2, 3, 4};
      chk("pin_model_a2", model(0, 2, xv), 10);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      xv = '{1, 2, 3, 4};
      send_frame(xv, 0);
      xv = '{-128, -128, -128, -128};
      send_frame(xv, 0);
      drain();

      // backpressure with in_valid pulses while outputs are stalled
      hold = 1;
      rand_vec(xv);
      send_frame(xv, 0);
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (out_valid_a) begin ok = 1; break; end
      end
      if (!ok) fail_now("wait_out_valid");
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 1) != 0);
         in_data = 8'($urandom_range(0, 255));
      end
      in_valid = 1'b0;
      hold = 0;
      drain();

      // reset during MAC of neuron 1
      rand_vec(xv);
      send_frame(xv, 0);
      ok = 0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (out_valid_a && out_ready && out_idx_a == 2'd0) begin ok = 1; break; end
      end
      if (!ok) fail_now("wait_neuron0");
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      @(posedge clk); #1;
      xv = '{1, 2, 3, 4};
      send_frame(xv, 0);
      drain();

      repeat (25) begin
         rand_vec(xv);
         send_frame(xv, 1);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
